score_keeper: RTL

Parametrised multi-player scoring engine for the whack-a-mole game, replacing the single-player 6-bit counter. It sits between the per-player hit/miss detectors and the display/VGA text layer. It tracks the game session, keeps a saturating score per player with a streak multiplier and a miss penalty, and latches a session-persistent high score when each game ends.

---
 rtl/score_pkg.sv | 33 +++
 rtl/score_lane.sv | 71 +++++++
 rtl/score_keeper.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared state encoding, widths and saturating
// arithmetic helpers for the whack-a-mole scoring engine.
package score_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   localparam int MULT_W = 3;

   // Wide enough that score/streak sums never wrap before clamping.
   typedef logic [31:0] calc_t;

   function automatic calc_t sat_add(
      input calc_t a,
      input calc_t b,
      input calc_t lim
   );
      calc_t s;
      s = a + b;
      return (s > lim) ? lim : s;
   endfunction

   function automatic calc_t sat_sub(
      input calc_t a,
      input calc_t b
   );
      return (a > b) ? (a - b) : '0;
   endfunction

endpackage

// File: rtl/score_lane.sv
// score_lane: one player's score, hit streak and multiplier,
// with saturating add on hits and floored penalty on misses.
module score_lane
   import score_pkg::*;
#(
   parameter int SCORE_W      = 8,
   parameter int STREAK_STEP  = 4,
   parameter int MAX_MULT     = 4,
   parameter int MISS_PENALTY = 1
) (
   input  logic               clkIn,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   input  logic               hit,
   input  logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [MULT_W-1:0]  mult,
   output logic [SCORE_W-1:0] score_nxt
);

   localparam int    SW         = SCORE_W + 3;
   localparam calc_t SCORE_MAX  = calc_t'(2**SCORE_W - 1);
   localparam calc_t STREAK_MAX = calc_t'(STREAK_STEP * (MAX_MULT - 1));
   localparam calc_t STEP       = calc_t'(STREAK_STEP);
   localparam calc_t MMAX       = calc_t'(MAX_MULT);
   localparam calc_t PEN        = calc_t'(MISS_PENALTY);

   logic [SW-1:0]     streak;
   logic [SW-1:0]     streak_nxt;
   logic [MULT_W-1:0] mult_nxt;
   calc_t             sc_c;
   calc_t             st_c;
   calc_t             mu_c;

   // Next score/streak/multiplier; a hit masks a same-cycle miss.
   always_comb begin
      sc_c = calc_t'(score);
      st_c = calc_t'(streak);
      if (en && hit) begin
         sc_c = sat_add(sc_c, calc_t'(mult), SCORE_MAX);
         st_c = sat_add(st_c, 32'd1, STREAK_MAX);
      end else if (en && miss) begin
         sc_c = sat_sub(sc_c, PEN);
         st_c = '0;
      end
      mu_c = 32'd1 + (st_c / STEP);
      if (mu_c > MMAX) mu_c = MMAX;
      score_nxt  = SCORE_W'(sc_c);
      streak_nxt = SW'(st_c);
      mult_nxt   = MULT_W'(mu_c);
   end

   // Lane state; clr starts a fresh round.
   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         score  <= '0;
         streak <= '0;
         mult   <= MULT_W'(1);
      end else if (clr) begin
         score  <= '0;
         streak <= '0;
         mult   <= MULT_W'(1);
      end else begin
         score  <= score_nxt;
         streak <= streak_nxt;
         mult   <= mult_nxt;
      end
   end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: session FSM, per-player scoring lanes,
// leader/tie tracking and session high score.
module score_keeper
   import score_pkg::*;
#(
   parameter int NUM_PLAYERS  = 2,
   parameter int SCORE_W      = 8,
   parameter int STREAK_STEP  = 4,
   parameter int MAX_MULT     = 4,
   parameter int MISS_PENALTY = 1
) (
   input  logic                           clkIn,
   input  logic                           reset,
   input  logic                           game_active,
   input  logic [NUM_PLAYERS-1:0]         hit,
   input  logic [NUM_PLAYERS-1:0]         miss,
   input  logic                           clear_high,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic [NUM_PLAYERS*MULT_W-1:0]  mult,
   output logic [1:0]                     state,
   output logic [1:0]                     leader,
   output logic                           tie,
   output logic [SCORE_W-1:0]             high_score,
   output logic [1:0]                     high_owner,
   output logic                           new_high
);

   localparam int VW = NUM_PLAYERS * SCORE_W;

   state_t             st;
   logic               act_q;
   logic               act_qq;
   logic               rise;
   logic               fall;
   logic               run;
   logic               clr;
   logic               eog;
   logic [VW-1:0]      nxt;
   logic [1:0]         lead_c;
   logic [SCORE_W-1:0] best_c;
   logic [2:0]         cnt_c;
   logic               tie_c;
   logic [1:0]         fidx_c;
   logic [SCORE_W-1:0] fbest_c;

   assign rise  = act_q & ~act_qq;
   assign fall  = ~act_q & act_qq;
   assign run   = (st == ST_RUN);
   assign clr   = rise & ~run;
   assign eog   = run & fall;
   assign state = st;

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
      score_lane #(
         .SCORE_W      (SCORE_W),
         .STREAK_STEP  (STREAK_STEP),
         .MAX_MULT     (MAX_MULT),
         .MISS_PENALTY (MISS_PENALTY)
      ) u_lane (
         .clkIn     (clkIn),
         .reset     (reset),
         .en        (run),
         .clr       (clr),
         .hit       (hit[i]),
         .miss      (miss[i]),
         .score     (scores[i*SCORE_W +: SCORE_W]),
         .mult      (mult[i*MULT_W +: MULT_W]),
         .score_nxt (nxt[i*SCORE_W +: SCORE_W])
      );
   end

   function automatic void arg_max(
      input  logic [VW-1:0]      v,
      output logic [1:0]         k,
      output logic [SCORE_W-1:0] b
   );
      b = v[SCORE_W-1:0];
      k = '0;
      for (int i = 1; i < NUM_PLAYERS; i++) begin
         if (v[i*SCORE_W +: SCORE_W] > b) begin
            b = v[i*SCORE_W +: SCORE_W];
            k = 2'(i);
         end
      end
   endfunction

   // Leader and tie from registered scores; final maximum from
   // next-cycle scores so a hit on the ending edge still counts.
   always_comb begin
      arg_max(scores, lead_c, best_c);
      arg_max(nxt, fidx_c, fbest_c);
      cnt_c = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (scores[i*SCORE_W +: SCORE_W] == best_c) cnt_c = cnt_c + 3'd1;
      end
      tie_c = (NUM_PLAYERS > 1) && (st != ST_IDLE) && (cnt_c > 3'd1);
   end

   // Edge detect on game_active and session FSM.
   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         act_q  <= 1'b0;
         act_qq <= 1'b0;
         st     <= ST_IDLE;
      end else begin
         act_q  <= game_active;
         act_qq <= act_q;
         unique case (st)
            ST_IDLE: if (rise) st <= ST_RUN;
            ST_RUN:  if (fall) st <= ST_HOLD;
            ST_HOLD: if (rise) st <= ST_RUN;
            default: st <= ST_IDLE;
         endcase
      end
   end

   // Registered leader/tie, one cycle behind scores.
   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         leader <= '0;
         tie    <= 1'b0;
      end else begin
         leader <= lead_c;
         tie    <= tie_c;
      end
   end

   // High score: end-of-game update takes priority over clear.
   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         high_score <= '0;
         high_owner <= '0;
         new_high   <= 1'b0;
      end else begin
         new_high <= 1'b0;
         if (eog && (fbest_c > high_score)) begin
            high_score <= fbest_c;
            high_owner <= fidx_c;
            new_high   <= 1'b1;
         end else if (clear_high) begin
            high_score <= '0;
            high_owner <= '0;
         end
      end
   end

endmodule
